// File: rtl/microsequencer_pkg.sv
// microsequencer_pkg: opcodes, T-state indices and sequencer state encoding
package microsequencer_pkg;
  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_HALT} seq_state_e;
  localparam logic [3:0] OP_LDA   = 4'h0;
  localparam logic [3:0] OP_STA   = 4'h1;
  localparam logic [3:0] OP_ADD_B = 4'h2;
  localparam logic [3:0] OP_ADD_C = 4'h3;
  localparam logic [3:0] OP_SUB_B = 4'h4;
  localparam logic [3:0] OP_SUB_C = 4'h5;
  localparam logic [3:0] OP_JMP   = 4'h6;
  localparam logic [3:0] OP_JC    = 4'h7;
  localparam logic [3:0] OP_JZ    = 4'h8;
  localparam logic [3:0] OP_OUT   = 4'h9;
  localparam logic [3:0] OP_HLT   = 4'hA;
  localparam int T0 = 0;
  localparam int T1 = 1;
  localparam int T2 = 2;
  localparam int T3 = 3;
  localparam int T4 = 4;
  localparam int T5 = 5;
endpackage

// File: rtl/microsequencer_ring.sv
// ring_counter_onehot: one-hot T-state ring that rotates on advance, or returns to T0 when wrap is also set
module ring_counter_onehot
  import microsequencer_pkg::*;
#(
  parameter int LEN = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           advance_i,
  input  logic           wrap_i,
  output logic [LEN-1:0] ring_o
);
  logic [LEN-1:0] ring_q;
  // rotate one place per advance; wrap ends the instruction early back at T0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ring_q <= LEN'(1) << T0;
    else if (advance_i) ring_q <= wrap_i ? LEN'(1) << T0 : {ring_q[LEN-2:0], ring_q[LEN-1]};
  end
  assign ring_o = ring_q;
endmodule

// File: rtl/microsequencer.sv
// microsequencer: self-timed 8-bit CPU controller with early instruction end and latched halt (optional SEQ_SINGLE_STEP_EN)
module microsequencer
  import microsequencer_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int OPCODE_W = 4,
  parameter int T_STATES = 10
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                step_mode,
  input  logic                step,
`endif
  input  logic [DATA_W-1:0]   instruction,
  input  logic                carry_flag,
  input  logic                zero_flag,
  output logic [T_STATES-1:0] ring_counter,
  output logic                instr_done,
  output logic                hlt_clk,
  output logic                count_pc,
  output logic                clear_pc,
  output logic                enable_pc,
  output logic                load_pc,
  output logic                load_accum,
  output logic                enable_accum,
  output logic                load_mar,
  output logic                ce_ram,
  output logic                we_ram,
  output logic                sub_mode,
  output logic                enable_alu,
  output logic                load_b_reg,
  output logic                enable_b_reg,
  output logic                load_c_reg,
  output logic                enable_c_reg,
  output logic                load_temp_reg,
  output logic                load_mdr_reg,
  output logic                enable_mdr_reg,
  output logic                load_output_reg,
  output logic                load_inst_reg,
  output logic                enable_inst_reg,
  output logic                clear_inst_reg,
  output logic                extended_fetch,
  output logic                enable_ring_counter
);
  if (OPCODE_W < 4 || OPCODE_W > DATA_W) begin : g_bad_opcode_w
    $error("microsequencer: OPCODE_W must lie in 4..DATA_W");
  end
  if (T_STATES < 6) begin : g_bad_t_states
    $error("microsequencer: T_STATES must be at least 6");
  end
  seq_state_e state_q, state_d;
  logic [T_STATES-1:0] ring_q, r;
  logic [OPCODE_W-1:0] op;
  logic run, adv, done, ring_hi;
  logic is_ldst, is_jmp, two, use_b, use_c, alu, take;
  logic unused_instr;
  function automatic logic is_op(input logic [OPCODE_W-1:0] o, input logic [3:0] c);
    return o == OPCODE_W'(c);
  endfunction
  assign op           = instruction[OPCODE_W-1:0];
  assign unused_instr = ^instruction;
  assign run          = state_q == ST_RUN;
  assign r            = run ? ring_q : '0;
  assign ring_hi      = run & ~|ring_q[T5:T0];
  assign is_ldst      = is_op(op, OP_LDA) | is_op(op, OP_STA);
  assign is_jmp       = is_op(op, OP_JMP) | is_op(op, OP_JC) | is_op(op, OP_JZ);
  assign two          = is_ldst | is_jmp;
  assign use_b        = is_op(op, OP_ADD_B) | is_op(op, OP_SUB_B);
  assign use_c        = is_op(op, OP_ADD_C) | is_op(op, OP_SUB_C);
  assign alu          = use_b | use_c;
  assign take         = is_op(op, OP_JMP) | (is_op(op, OP_JC) & carry_flag) | (is_op(op, OP_JZ) & zero_flag);
`ifdef SEQ_SINGLE_STEP_EN
  logic step_q;
  // previous step sample for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_q <= 1'b0;
    else step_q <= step;
  end
  assign adv = ~step_mode | (step & ~step_q);
`else
  assign adv = 1'b1;
`endif
  ring_counter_onehot #(.LEN(T_STATES)) u_ring (
    .clk      (clk),
    .rst_n    (rst_n),
    .advance_i(run & adv),
    .wrap_i   (done),
    .ring_o   (ring_q)
  );
  // sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_INIT;
    else state_q <= state_d;
  end
  // next state and control strobes decoded from state, ring and opcode
  always_comb begin
    state_d             = state_q;
    done                = (r[T2] & ~two & ~alu) | (r[T3] & alu) | (r[T4] & is_jmp) | (r[T5] & is_ldst) | ring_hi;
    state_d             = state_q == ST_INIT ? ST_RUN : (done & adv & is_op(op, OP_HLT)) ? ST_HALT : state_q;
    instr_done          = done;
    clear_pc            = state_q == ST_INIT;
    clear_inst_reg      = state_q == ST_INIT;
    hlt_clk             = state_q == ST_HALT | (r[T2] & is_op(op, OP_HLT));
    enable_ring_counter = run & adv;
    enable_pc           = r[T0] | (r[T2] & two);
    load_mar            = r[T0] | (r[T2] & two) | (r[T4] & is_ldst);
    ce_ram              = r[T1] | (r[T3] & two) | (r[T5] & is_ldst);
    count_pc            = r[T1] | (r[T3] & two);
    load_inst_reg       = r[T1];
    extended_fetch      = (r[T2] | r[T3]) & two;
    load_mdr_reg        = r[T3] & two;
    enable_b_reg        = r[T2] & use_b;
    enable_c_reg        = r[T2] & use_c;
    load_temp_reg       = r[T2] & alu;
    enable_alu          = r[T3] & alu;
    sub_mode            = r[T3] & (is_op(op, OP_SUB_B) | is_op(op, OP_SUB_C));
    load_accum          = (r[T3] & alu) | (r[T5] & is_op(op, OP_LDA));
    enable_accum        = (r[T2] & is_op(op, OP_OUT)) | (r[T5] & is_op(op, OP_STA));
    we_ram              = r[T5] & is_op(op, OP_STA);
    load_output_reg     = r[T2] & is_op(op, OP_OUT);
    enable_mdr_reg      = r[T4] & (is_ldst | take);
    load_pc             = r[T4] & take;
    load_b_reg          = 1'b0;
    load_c_reg          = 1'b0;
    enable_inst_reg     = 1'b0;
  end
  assign ring_counter = r;
endmodule
